// File: rtl/pool_stage_pkg.sv
// rtl/pool_stage_pkg.sv - shared defaults and signed max helper for the conv/pool datapath
package pool_stage_pkg;

    localparam int POOL_DATA_W   = 32;
    localparam int POOL_IN_SIZE  = 28;
    localparam int POOL_NUM_MAPS = 6;

    // Fixed output field widths of the pooled-pixel tag
    localparam int MAP_W = 3;
    localparam int POS_W = 4;

    // Widest datapath the max helper supports; narrower callers sign-extend in and truncate out
    localparam int MAX_W = 64;

    // Signed two's-complement max; on a tie either operand is the same value
    function automatic logic signed [MAX_W-1:0] smax(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - half-row store of horizontal maxima from the even row of each window pair
module pool_linebuf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 14,
    parameter int AW     = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    // No reset on storage so it can map onto a small RAM
    logic signed [DATA_W-1:0] mem [DEPTH];

    // Single write port, written only while the even row of a pair streams in
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read, used only on odd rows so it never collides with a write
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool_stage.sv
// rtl/pool_stage.sv - streaming ReLU + 2x2 max-pool over raster-ordered conv feature maps
module pool_stage
    import pool_stage_pkg::*;
#(
    parameter int DATA_W   = POOL_DATA_W,
    parameter int IN_SIZE  = POOL_IN_SIZE,
    parameter int NUM_MAPS = POOL_NUM_MAPS,
    parameter int RELU_EN  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic [MAP_W-1:0]         out_map,
    output logic [POS_W-1:0]         out_row,
    output logic [POS_W-1:0]         out_col,
    output logic                     frame_done
);

    localparam int CW   = $clog2(IN_SIZE);
    localparam int HALF = IN_SIZE / 2;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]            col;
    logic [CW-1:0]            row;
    logic [MAP_W-1:0]         map;
    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] hm;
    logic signed [DATA_W-1:0] lb_rd;
    logic signed [DATA_W-1:0] win_max;
    logic                     last_col;
    logic                     last_row;
    logic                     last_map;
    logic                     beat;
    logic                     lb_we;
    logic [AW-1:0]            lb_addr;

    // ReLU, horizontal max against the held even-column pixel, and vertical max against the line buffer
    always_comb begin
        pix = in_data;
        if (RELU_EN != 0 && in_data[DATA_W-1]) begin
            pix = '0;
        end
        hm      = DATA_W'(smax(MAX_W'(hold), MAX_W'(pix)));
        win_max = DATA_W'(smax(MAX_W'(lb_rd), MAX_W'(hm)));
    end

    // Position decode; clear suppresses the line buffer write of a dropped beat
    always_comb begin
        last_col = (col == CW'(IN_SIZE - 1));
        last_row = (row == CW'(IN_SIZE - 1));
        last_map = (map == MAP_W'(NUM_MAPS - 1));
        beat     = in_valid & ~clear;
        lb_we    = beat & ~row[0] & col[0];
        lb_addr  = AW'(col >> 1);
    end

    pool_linebuf #(
        .DATA_W (DATA_W),
        .DEPTH  (HALF),
        .AW     (AW)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (hm),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    // Raster counters: col, then row, then map; advance only on accepted beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
            map <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
            map <= '0;
        end else if (in_valid) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row <= '0;
                    map <= last_map ? '0 : map + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Even-column pixel held for the horizontal compare on the following odd column
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
        end else if (clear) begin
            hold <= '0;
        end else if (in_valid && !col[0]) begin
            hold <= pix;
        end
    end

    // Registered result on the bottom-right pixel of each window; fields hold between strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_map    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid && row[0] && col[0]) begin
                out_valid  <= 1'b1;
                out_data   <= win_max;
                out_map    <= map;
                out_row    <= POS_W'(row >> 1);
                out_col    <= POS_W'(col >> 1);
                frame_done <= last_col & last_row & last_map;
            end
        end
    end

endmodule

// File: tb/tb_pool_stage.sv
// tb/tb_pool_stage.sv - directed table-driven bench for pool_stage
module tb_pool_stage;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic signed [31:0] in_data;

    logic               out_valid;
    logic signed [31:0] out_data;
    logic [2:0]         out_map;
    logic [3:0]         out_row;
    logic [3:0]         out_col;
    logic               frame_done;

    logic               nr_valid;
    logic signed [31:0] nr_data;
    logic [2:0]         nr_map;
    logic [3:0]         nr_row;
    logic [3:0]         nr_col;
    logic               nr_frame_done;

    int checks = 0;
    int errors = 0;

    int ov_cnt = 0;
    int fd_cnt = 0;
    int fd_map = -1;
    int fd_row = -1;
    int fd_col = -1;

    longint exp_hold = 0;
    bit     got_first;
    longint first_v, first_nr, last_v, last_nr;

    pool_stage #(.RELU_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_map    (out_map),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    pool_stage #(.RELU_EN(0)) dut_nr (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (nr_valid),
        .out_data   (nr_data),
        .out_map    (nr_map),
        .out_row    (nr_row),
        .out_col    (nr_col),
        .frame_done (nr_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1) ov_cnt <= ov_cnt + 1;
        if (frame_done === 1'b1) begin
            fd_cnt <= fd_cnt + 1;
            fd_map <= int'(out_map);
            fd_row <= int'(out_row);
            fd_col <= int'(out_col);
        end
    end

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // pattern 0 ramp, 1 constant -5, 2 single peak 1000 at (3,2) over 1s, 3 negative ramp
    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return r * 28 + c;
            1:       return -5;
            2:       return (r == 3 && c == 2) ? 1000 : 1;
            default: return -(r * 28 + c) - 1;
        endcase
    endfunction

    function automatic int exp_out(input int pat, input int i, input int j, input bit relu);
        case (pat)
            0:       return (2 * i + 1) * 28 + 2 * j + 1;
            1:       return relu ? 0 : -5;
            2:       return (i == 1 && j == 1) ? 1000 : 1;
            default: return relu ? 0 : -((2 * i) * 28 + 2 * j) - 1;
        endcase
    endfunction

    // Entered just after a negedge; drives nbeats pixels of one map and checks each result a cycle later
    task automatic run_map(input int pat, input bit gaps, input int tag, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            int r;
            int c;
            int e;
            int en;
            r = k / 28;
            c = k % 28;
            in_valid = 1'b1;
            in_data  = pix(pat, r, c);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
            if (r % 2 == 1 && c % 2 == 1) begin
                e  = exp_out(pat, r / 2, c / 2, 1'b1);
                en = exp_out(pat, r / 2, c / 2, 1'b0);
                check_int("out_valid", out_valid, 1);
                check_int("out_data", out_data, e);
                check_int("out_map", out_map, tag);
                check_int("out_row", out_row, r / 2);
                check_int("out_col", out_col, c / 2);
                check_int("frame_done", frame_done, (tag == 5 && r == 27 && c == 27) ? 1 : 0);
                check_int("norelu_valid", nr_valid, 1);
                check_int("norelu_data", nr_data, en);
                exp_hold = e;
                if (!got_first) begin
                    got_first = 1'b1;
                    first_v   = out_data;
                    first_nr  = nr_data;
                end
                last_v  = out_data;
                last_nr = nr_data;
            end else begin
                check_int("idle_out_valid", out_valid, 0);
                check_int("idle_frame_done", frame_done, 0);
                check_int("idle_out_data_hold", out_data, exp_hold);
                check_int("idle_norelu_valid", nr_valid, 0);
            end
            if (gaps) begin
                @(posedge clk);
                @(negedge clk);
                check_int("gap_out_valid", out_valid, 0);
                check_int("gap_out_data_hold", out_data, exp_hold);
            end
        end
    endtask

    // One idle-input clear cycle; out_valid must be low afterwards
    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check_int("clear_out_valid", out_valid, 0);
        check_int("clear_frame_done", frame_done, 0);
    endtask

    typedef struct {
        int pat;
        bit gaps;
        int exp_cnt;
        int exp_first;
        int exp_first_nr;
        int exp_last;
        int exp_last_nr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base_ov;
        int base_fd;

        vecs[0] = '{0, 1'b0, 196, 29, 29, 783, 783};
        vecs[1] = '{1, 1'b0, 196, 0, -5, 0, -5};
        vecs[2] = '{2, 1'b0, 196, 1, 1, 1, 1};
        vecs[3] = '{2, 1'b1, 196, 1, 1, 1, 1};
        vecs[4] = '{3, 1'b0, 196, 0, -1, 0, -755};
        vecs[5] = '{0, 1'b1, 196, 29, 29, 783, 783};

        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #3 rst = 1'b0;
        #5;
        check_int("reset_out_valid", out_valid, 0);
        check_int("reset_out_data", out_data, 0);
        check_int("reset_out_map", out_map, 0);
        check_int("reset_out_row", out_row, 0);
        check_int("reset_out_col", out_col, 0);
        check_int("reset_frame_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_hold = 0;

        // Single-map vectors, each started from a clear
        for (int v = 0; v < 6; v++) begin
            do_clear();
            @(posedge clk);
            #1 base_ov = ov_cnt;
            @(negedge clk);
            got_first = 1'b0;
            run_map(vecs[v].pat, vecs[v].gaps, 0, 784);
            @(posedge clk);
            #1;
            check_int($sformatf("vec%0d_count", v), ov_cnt - base_ov, vecs[v].exp_cnt);
            check_int($sformatf("vec%0d_first", v), first_v, vecs[v].exp_first);
            check_int($sformatf("vec%0d_first_norelu", v), first_nr, vecs[v].exp_first_nr);
            check_int($sformatf("vec%0d_last", v), last_v, vecs[v].exp_last);
            check_int($sformatf("vec%0d_last_norelu", v), last_nr, vecs[v].exp_last_nr);
            @(negedge clk);
        end

        // Full six-map frame, then the next beat must begin map 0 at (0,0)
        do_clear();
        @(posedge clk);
        #1;
        base_ov = ov_cnt;
        base_fd = fd_cnt;
        @(negedge clk);
        for (int m = 0; m < 6; m++) run_map(0, 1'b0, m, 784);
        @(posedge clk);
        #1;
        check_int("frame_pulses", ov_cnt - base_ov, 1176);
        check_int("frame_done_count", fd_cnt - base_fd, 1);
        check_int("frame_done_map", fd_map, 5);
        check_int("frame_done_row", fd_row, 13);
        check_int("frame_done_col", fd_col, 13);
        @(negedge clk);
        run_map(0, 1'b0, 0, 56);

        // Reset in the middle of map 2 row 9, then a fresh map
        do_clear();
        run_map(0, 1'b0, 0, 784);
        run_map(0, 1'b0, 1, 784);
        run_map(0, 1'b0, 2, 9 * 28 + 5);
        rst = 1'b0;
        #1;
        check_int("midreset_out_valid", out_valid, 0);
        check_int("midreset_out_data", out_data, 0);
        check_int("midreset_out_map", out_map, 0);
        check_int("midreset_out_row", out_row, 0);
        check_int("midreset_out_col", out_col, 0);
        exp_hold = 0;
        @(negedge clk);
        rst = 1'b1;
        run_map(0, 1'b0, 0, 784);

        // Clear coinciding with the beat of map 1 pixel (5,5): beat dropped, restart at map 0
        do_clear();
        run_map(0, 1'b0, 0, 784);
        run_map(0, 1'b0, 1, 5 * 28 + 5);
        in_valid = 1'b1;
        in_data  = pix(0, 5, 5);
        clear    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_int("clear_beat_out_valid", out_valid, 0);
        check_int("clear_beat_out_data_hold", out_data, exp_hold);
        check_int("clear_beat_norelu_valid", nr_valid, 0);
        run_map(0, 1'b0, 0, 56);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
